// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch sequencer.
package rv32i_fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  localparam int unsigned PC_W            = 32;
  localparam int unsigned PC_STEP         = 4;
  localparam int unsigned BYTE_OFFSET_W   = 2;
  localparam int unsigned FETCH_BUF_DEPTH = 2;
  localparam int unsigned BUF_COUNT_W     = $clog2(FETCH_BUF_DEPTH + 1);

endpackage

// File: rtl/instruction_fetch_sequencer_buffer.sv
// Small shift-register FIFO holding fetched {pc, instruction} pairs; head is always entry 0.
module fetch_buffer
  import rv32i_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [BUF_COUNT_W-1:0] count,
  output logic [DATA_W-1:0]      head
);

  localparam int unsigned IDX_W = (FETCH_BUF_DEPTH > 1) ? $clog2(FETCH_BUF_DEPTH) : 1;
  localparam logic [BUF_COUNT_W-1:0] DEPTH_C = BUF_COUNT_W'(FETCH_BUF_DEPTH);
  localparam logic [BUF_COUNT_W-1:0] ONE_C   = BUF_COUNT_W'(1);

  logic [DATA_W-1:0]      entry_q [FETCH_BUF_DEPTH];
  logic [DATA_W-1:0]      entry_d [FETCH_BUF_DEPTH];
  logic [BUF_COUNT_W-1:0] count_q, count_d;

  // Pop shifts first, so a same-cycle push lands behind the surviving entries.
  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop && (count_q != '0)) begin
        for (int i = 0; i < FETCH_BUF_DEPTH - 1; i++) begin
          entry_d[IDX_W'(i)] = entry_q[IDX_W'(i + 1)];
        end
        count_d = count_q - ONE_C;
      end
      if (push && (count_d < DEPTH_C)) begin
        entry_d[IDX_W'(count_d)] = push_data;
        count_d = count_d + ONE_C;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '{default: '0};
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = entry_q[0];

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Fetch PC, credit-based read issue and fault FSM in front of a synchronous-read instruction memory.
module instruction_fetch_sequencer
  import rv32i_fetch_pkg::*;
#(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned INST_DEPTH = 16,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_en,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          mem_rd_en,
  output logic [$clog2(INST_DEPTH)-1:0] mem_rd_addr,
  input  logic [INST_WIDTH-1:0]         mem_instruction,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [INST_WIDTH-1:0]         inst_data,
  output logic [31:0]                   inst_pc,
  output logic                          fetch_fault
);

  localparam int unsigned AW      = $clog2(INST_DEPTH);
  localparam int unsigned ENTRY_W = PC_W + INST_WIDTH;
  localparam int unsigned WORD_W  = PC_W - BYTE_OFFSET_W;
  localparam int unsigned CW      = BUF_COUNT_W + 1;
  localparam logic [WORD_W-1:0] DEPTH_WORDS = WORD_W'(INST_DEPTH);
  localparam logic [CW-1:0]     CREDITS     = CW'(FETCH_BUF_DEPTH);

  fetch_state_t           state_q, state_d;
  logic [PC_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]        inflight_pc_q, inflight_pc_d;
  logic                   inflight_q, inflight_d;
  logic [BUF_COUNT_W-1:0] buf_count;
  logic [ENTRY_W-1:0]     buf_head;
  logic                   pop, pc_ok, credit_ok, issue;

  assign inst_valid           = (buf_count != '0);
  assign pop                  = inst_valid && inst_ready;
  assign {inst_pc, inst_data} = buf_head;
  assign fetch_fault          = (state_q == FAULT);

  // A read is only legal for an aligned PC inside the memory.
  assign pc_ok = (fetch_pc_q[BYTE_OFFSET_W-1:0] == '0) &&
                 (fetch_pc_q[PC_W-1:BYTE_OFFSET_W] < DEPTH_WORDS);

  // Occupied plus in-flight slots, less this cycle's pop, must leave room for one more word.
  assign credit_ok = ({1'b0, buf_count} + CW'(inflight_q)) < (CREDITS + CW'(pop));

  assign issue = !rst && (state_q == FETCH) && fetch_en && !redirect_valid && credit_ok && pc_ok;

  assign mem_rd_en   = issue;
  assign mem_rd_addr = fetch_pc_q[AW+BYTE_OFFSET_W-1:BYTE_OFFSET_W];

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      state_d    = FETCH;
      fetch_pc_d = redirect_pc;
    end else if (state_q == FETCH) begin
      if (!pc_ok) begin
        state_d = FAULT;
      end else if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_W'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // A redirect flush wins over the response that would otherwise land this cycle.
  fetch_buffer #(
    .DATA_W(ENTRY_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data({inflight_pc_q, mem_instruction}),
    .pop      (pop),
    .flush    (redirect_valid),
    .count    (buf_count),
    .head     (buf_head)
  );

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Scoreboard bench: the expected instruction stream is the sequential legal-PC run from the last reset/redirect.
module tb_instruction_fetch_sequencer;

  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned INST_DEPTH = 16;
  localparam int unsigned AW         = $clog2(INST_DEPTH);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  fetch_en;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  mem_rd_en;
  logic [AW-1:0]         mem_rd_addr;
  logic [INST_WIDTH-1:0] mem_instruction;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [INST_WIDTH-1:0] inst_data;
  logic [31:0]           inst_pc;
  logic                  fetch_fault;

  logic [INST_WIDTH-1:0] mem [INST_DEPTH];
  logic [31:0]           exp_q [$];
  int                    checks = 0;
  int                    errors = 0;
  int                    pops   = 0;
  logic                  hold_v = 1'b0;
  logic [31:0]           hold_pc;
  logic [INST_WIDTH-1:0] hold_d;
  logic [31:0]           mon_e;

  instruction_fetch_sequencer #(
    .INST_WIDTH(INST_WIDTH),
    .INST_DEPTH(INST_DEPTH),
    .RESET_PC  (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_instruction(mem_instruction),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) if (mem_rd_en) mem_instruction <= mem[mem_rd_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every aligned, in-range PC from start onward, in order, until the first illegal one.
  function automatic void build_stream(input logic [31:0] start);
    logic [31:0] p;
    p = start;
    exp_q.delete();
    while (p[1:0] == 2'b00 && (p >> 2) < INST_DEPTH) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endfunction

  // Monitor: compares every accepted instruction and a few black-box rules.
  always @(negedge clk) begin
    if (rst) begin
      build_stream(32'h0);
      hold_v = 1'b0;
    end else begin
      if (hold_v && inst_valid) begin
        check("hold_pc", inst_pc, hold_pc);
        check("hold_data", inst_data, hold_d);
      end
      if (inst_valid && inst_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_inst actual_pc=%0h required=none", inst_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("inst_pc", inst_pc, mon_e);
          check("inst_data", inst_data, mem[mon_e[AW+1:2]]);
        end
      end
      if (mem_rd_en) check("rd_allowed", fetch_en && !redirect_valid && !fetch_fault, 1);
      if (fetch_fault && !inst_valid) check("fault_after_all_legal", exp_q.size(), 0);
      if (redirect_valid) build_stream(redirect_pc);
      hold_v  = inst_valid && !inst_ready && !redirect_valid;
      hold_pc = inst_pc;
      hold_d  = inst_data;
    end
  end

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!inst_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic redirect(input logic [31:0] pc, output logic valid_at);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    valid_at = inst_valid;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  // Legal redirect target: read next cycle, two empty cycles, head at redirect+3.
  task automatic restart_checks(input logic [31:0] pc);
    @(negedge clk);
    check("restart_gap1", inst_valid, 0);
    check("restart_rd_en", mem_rd_en, 1);
    check("restart_rd_addr", mem_rd_addr, pc[AW+1:2]);
    check("restart_fault_clear", fetch_fault, 0);
    @(negedge clk);
    check("restart_gap2", inst_valid, 0);
    @(negedge clk);
    check("restart_valid", inst_valid, 1);
    check("restart_pc", inst_pc, pc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_rd_addr"}, mem_rd_addr, 0);
    check({tag, "_valid"}, inst_valid, 0);
    check({tag, "_data"}, inst_data, 0);
    check({tag, "_pc"}, inst_pc, 0);
    check({tag, "_fault"}, fetch_fault, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic pv;
    for (int i = 0; i < INST_DEPTH; i++) mem[i] = 32'h13 + 32'(i);
    rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

    // Reset values and first-fetch latency.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("first_rd_en", mem_rd_en, 1);
    wait_valid(10, n);
    check("first_valid_cycle", n, 2);
    check("first_pc", inst_pc, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stream_no_gap", inst_valid, 1);
    end

    // Backpressure: head held at PC 0, issue stops, resumes on the pop cycle.
    redirect(32'h0, pv);
    inst_ready = 1'b0;
    restart_checks(32'h0);
    repeat (3) begin
      @(negedge clk);
      check("bp_rd_stall", mem_rd_en, 0);
      check("bp_head_pc", inst_pc, 32'h0);
      check("bp_head_data", inst_data, 32'h13);
    end
    @(posedge clk); #1 inst_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_rd_en", mem_rd_en, 1);
    check("bp_resume_addr", mem_rd_addr, 2);
    repeat (6) @(negedge clk);

    // Redirect while the PC 8 read is in flight.
    redirect(32'h0, pv);
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("pc8_rd_en", mem_rd_en, 1);
    check("pc8_rd_addr", mem_rd_addr, 2);
    redirect(32'h20, pv);
    restart_checks(32'h20);

    // Run off the end of memory.
    n = 0;
    while (!(mem_rd_en && mem_rd_addr == 4'hF) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_last_word", n < 40, 1);
    @(negedge clk);
    check("oob_no_read", mem_rd_en, 0);
    check("oob_fault_not_yet", fetch_fault, 0);
    @(negedge clk);
    check("oob_fault", fetch_fault, 1);
    repeat (4) @(negedge clk);
    check("oob_fault_held", fetch_fault, 1);
    check("oob_drained", inst_valid, 0);
    check("oob_no_read_held", mem_rd_en, 0);
    redirect(32'h4, pv);
    restart_checks(32'h4);

    // Misaligned redirect.
    redirect(32'h6, pv);
    @(negedge clk);
    check("mis_no_read", mem_rd_en, 0);
    check("mis_fault_not_yet", fetch_fault, 0);
    @(negedge clk);
    check("mis_fault", fetch_fault, 1);
    check("mis_no_read2", mem_rd_en, 0);

    // Redirect coinciding with a pop.
    redirect(32'h0, pv);
    restart_checks(32'h0);
    redirect(32'h10, pv);
    check("redir_pop_valid", pv, 1);
    restart_checks(32'h10);

    // Asynchronous reset with a word buffered and a read in flight.
    redirect(32'h0, pv);
    inst_ready = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("pre_rst_valid", inst_valid, 1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    inst_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_rd_en", mem_rd_en, 1);
    check("post_rst_rd_addr", mem_rd_addr, 0);
    wait_valid(10, n);
    check("post_rst_valid_cycle", n, 2);
    check("post_rst_pc", inst_pc, 32'h0);

    // Randomized traffic against the stream model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst            = ($urandom_range(0, 999) < 3);
      fetch_en       = ($urandom_range(0, 99) < 85);
      inst_ready     = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 5);
      case ($urandom_range(0, 9))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'($urandom_range(0, 63));
        2:       redirect_pc = 32'($urandom_range(12, 15) * 4);
        default: redirect_pc = 32'($urandom_range(0, 15) * 4);
      endcase
    end
    @(posedge clk); #1;
    rst = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("random_traffic_flowed", pops > 300, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_sequencer.md
# instruction_fetch_sequencer

Sequences the synchronous-read instruction memory for the RV32I core: holds the fetch PC, issues one word read per cycle, absorbs the one-cycle read latency in a 2-entry buffer, and presents instructions to decode through a valid/ready handshake. Sits between the `InstructionMemory` read port and the decode stage. Handles branch/jump redirects, stalls and out-of-range fetches.

## Interface

- `INST_WIDTH`, 32: instruction word width.
- `INST_DEPTH`, 16: memory depth in words. `AW = $clog2(INST_DEPTH)`.
- `RESET_PC`, 32'h0: byte address of the first fetch.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `fetch_en`  in  1  high permits new reads; low stalls issue only.
- `redirect_valid`  in  1  one-cycle pulse, load new PC and flush.
- `redirect_pc`  in  32  byte address for the redirect.
- `mem_rd_en`  out  1  to memory `rd_en`.
- `mem_rd_addr`  out  AW  to memory `rd_addr`, word index `fetch_pc[AW+1:2]`.
- `mem_instruction`  in  INST_WIDTH  memory data, valid the cycle after `mem_rd_en` is sampled.
- `inst_valid`  out  1  buffer head valid.
- `inst_ready`  in  1  decode accepts the head.
- `inst_data`  out  INST_WIDTH  head instruction.
- `inst_pc`  out  32  byte PC of the head.
- `fetch_fault`  out  1  misaligned or out-of-range fetch PC, held until redirect.

## Operation

- State `FETCH` or `FAULT`. Registers: `fetch_pc`, `inflight` (1 bit), `inflight_pc`, buffer `count` (0..2).
- Issue condition in `FETCH`: `fetch_en && !redirect_valid && (count + inflight - pop) < 2`, where `pop = inst_valid && inst_ready`. `mem_rd_en` and `mem_rd_addr` are combinational from the registers and `redirect_valid`. On issue: `inflight <= 1`, `inflight_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`. The address wraps modulo 2^32. No special case exists beyond the range check.
- Before issue, if `fetch_pc[1:0] != 0` or `fetch_pc[31:2] >= INST_DEPTH`, there is no read. The next state is `FAULT`, with `fetch_fault = 1`. Words already buffered still drain normally.
- Response: in the cycle after an issue, if `inflight = 1`, write `{inflight_pc, mem_instruction}` into the buffer. Then clear `inflight`, unless a new issue occurs in the same cycle.
- Buffer: FIFO order. Push and pop may occur in the same cycle. Overflow is impossible by construction of the credit check.
- Redirect: has priority over every other event. In the redirect cycle the pop handshake still completes. At the edge:
  - the buffer is cleared;
  - `inflight` is cleared, so the in-flight response is dropped;
  - `fetch_pc <= redirect_pc`;
  - state returns to `FETCH` and `fetch_fault` clears. A redirect is the only exit from `FAULT`.
- `fetch_en` low: no new issue. The in-flight response still lands in the buffer.
- Reset, including mid-operation: `fetch_pc = RESET_PC`, `inflight = 0`, `count = 0`, state `FETCH`. Any response arriving after reset is ignored.

## Timing

- Reset values: `mem_rd_en = 0`, `inst_valid = 0`, `inst_data = 0`, `inst_pc = 0`, `fetch_fault = 0`. `mem_rd_addr` = word index of `RESET_PC`.
- First read: `mem_rd_en` is high in the first cycle after `rst` deasserts, if `fetch_en = 1`.
- Read issued in cycle c → data on `mem_instruction` in c+1 → `inst_valid` in c+2.
- Redirect in cycle r → read of `redirect_pc` in r+1 → `inst_valid` in r+3.
- `inst_valid` is low in r+1 and r+2.
- Steady state with `inst_ready = 1` sustains one instruction per cycle.
- `inst_ready` low for 2+ cycles: the buffer fills to 2 and issue stops. The first read resumes in the cycle `pop` is observed.
- `fetch_fault` rises in the cycle after the offending PC is loaded. It falls in the cycle after the redirect.
- `inst_data`/`inst_pc` are held stable while `inst_valid && !inst_ready`.

## Structure

- Package `rv32i_fetch_pkg`:
  - `fetch_state_t` {`FETCH`, `FAULT`}
  - `PC_STEP = 4`
  - `BYTE_OFFSET_W = 2`
  - `FETCH_BUF_DEPTH = 2`
- Sub-module `fetch_buffer`: 2-entry synchronous FIFO of `{pc[31:0], instr[INST_WIDTH-1:0]}`. Ports: push, pop, flush, count, head. Same clock and reset.
- The top level holds the PC, credit logic and FSM, and drives the memory port directly.

## Test plan

- Reset with `RESET_PC = 0` and memory words `0x00000013 + i`, `inst_ready = 1` → `inst_valid` first in cycle 3 after reset release. Then PCs 0,4,8,... with data `0x13,0x14,...`, one per cycle, no gaps.
- Backpressure: hold `inst_ready = 0` for 5 cycles → `count` saturates at 2 and `mem_rd_en` goes low. The head stays PC 0 with stable data. On release, the order is unbroken with no lost or duplicated PC.
- Redirect to `0x20` while a read of PC 8 is in flight → the PC 8 word never appears. `inst_valid` is low for 2 cycles, then the next `inst_pc` is `0x20` at redirect+3.
- Run to PC `0x3C` with `INST_DEPTH = 16` → PC `0x40` is never read and `fetch_fault = 1`. Buffered words drain. A redirect to `0x4` clears the fault and fetch resumes at `0x4`.
- Redirect to `0x6` (misaligned) → no read, `fetch_fault = 1` the next cycle. Redirect plus simultaneous pop in the same cycle → the pop completes, the buffer is flushed, and the new PC is fetched.
- Assert `rst` with 2 entries buffered and a read in flight → all outputs return to reset values immediately. After release, fetch restarts at `RESET_PC` and the stale response is not buffered.
